// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: image geometry and the image-writer FSM encoding,
// used by the image RAM front end and the convolution blocks.
package lenet_pkg;

    // Input image geometry (MNIST-style 28x28 greyscale frame).
    localparam int IMG_ROWS   = 28;
    localparam int IMG_COLS   = 28;
    localparam int IMG_PIXELS = IMG_ROWS * IMG_COLS;

    // Image RAM writer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } writer_state_t;

endpackage : lenet_pkg

// File: rtl/image_ram_wrapper.sv
// Simple dual-port image RAM: port A read/write, port B read-only.
// Both read ports are registered (one-cycle read latency) so the array maps
// onto block RAM.
module image_ram_wrapper #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] ram_reg [0:DEPTH-1];

    // Port A: write when enabled, registered read-before-write data out.
    always_ff @(posedge clk) begin
        if (ena) begin
            if (wea) begin
                ram_reg[addra] <= dina;
            end
            douta <= ram_reg[addra];
        end
    end

    // Port B: registered read.
    always_ff @(posedge clk) begin
        if (enb) begin
            doutb <= ram_reg[addrb];
        end
    end

endmodule : image_ram_wrapper

// File: rtl/image_ram_writer.sv
// Streams one image frame into the image RAM through port A.
// Pixels arrive on a valid/ready stream and are written at consecutive
// addresses from 0; after the frame the rest of the RAM is optionally
// zero-filled so stale data from an earlier frame never leaks into the
// convolution window. Frame length problems are flagged on a sticky err_len.
module image_ram_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int IMG_PIXELS = lenet_pkg::IMG_PIXELS,
    parameter int PAD_ZERO   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len
);

    import lenet_pkg::*;

    // Index of the final pixel of a well-formed frame, and the top RAM address.
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMG_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = {ADDR_WIDTH{1'b1}};

    writer_state_t         state_reg, state_next;
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
    logic                  ena_reg, ena_next;
    logic                  wea_reg, wea_next;
    logic [ADDR_WIDTH-1:0] addra_reg, addra_next;
    logic [DATA_WIDTH-1:0] dina_reg, dina_next;
    logic                  err_len_reg, err_len_next;

    logic                  accept;
    logic                  at_last_idx;
    logic                  frame_end;
    logic                  len_bad;
    logic                  pad_end;
    logic [ADDR_WIDTH-1:0] idx_inc;

    // A beat is taken only while loading; s_ready is simply the LOAD state.
    assign accept      = (state_reg == ST_LOAD) && s_valid;
    assign at_last_idx = (idx_reg == LAST_IDX);
    // The frame ends either on the nominal last index or on an explicit s_last.
    assign frame_end   = s_last || at_last_idx;
    // s_last and the nominal last index must coincide; either alone is an error.
    assign len_bad     = s_last ^ at_last_idx;
    // Padding finishes once the write to the top address is on the port.
    assign pad_end     = wea_reg && (addra_reg == MAX_ADDR);
    // Saturating index increment: the counter parks at the top address.
    assign idx_inc     = (idx_reg == MAX_ADDR) ? idx_reg : idx_reg + 1'b1;

    // Next-state and next-output logic for the writer FSM.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        ena_next     = 1'b0;
        wea_next     = 1'b0;
        addra_next   = addra_reg;
        dina_next    = dina_reg;
        err_len_next = err_len_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_LOAD;
                    idx_next     = '0;
                    err_len_next = 1'b0;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    ena_next   = 1'b1;
                    wea_next   = 1'b1;
                    addra_next = idx_reg;
                    dina_next  = s_data;
                    idx_next   = idx_inc;
                    if (len_bad) begin
                        err_len_next = 1'b1;
                    end
                    if (frame_end) begin
                        state_next = (PAD_ZERO != 0) ? ST_PAD : ST_DONE;
                    end
                end
            end

            ST_PAD: begin
                if (pad_end) begin
                    state_next = ST_DONE;
                end else begin
                    ena_next   = 1'b1;
                    wea_next   = 1'b1;
                    addra_next = idx_reg;
                    dina_next  = '0;
                    idx_next   = idx_inc;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered RAM port; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            ena_reg     <= 1'b0;
            wea_reg     <= 1'b0;
            addra_reg   <= '0;
            dina_reg    <= '0;
            err_len_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            ena_reg     <= ena_next;
            wea_reg     <= wea_next;
            addra_reg   <= addra_next;
            dina_reg    <= dina_next;
            err_len_reg <= err_len_next;
        end
    end

    assign s_ready = (state_reg == ST_LOAD);
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign ena     = ena_reg;
    assign wea     = wea_reg;
    assign addra   = addra_reg;
    assign dina    = dina_reg;
    assign err_len = err_len_reg;

endmodule : image_ram_writer

// File: doc/image_ram_writer.md
IMAGE_RAM_WRITER -- requirements
Module: image_ram_writer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 10, image RAM address width.
- IMG_PIXELS, 784, pixels per frame (28x28).
- PAD_ZERO, 1, when 1, zero-fill addresses IMG_PIXELS..2^ADDR_WIDTH-1 after each frame.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is rising-edge.
- rst_n, in, 1, reset; synchronous, active-low.
- start, in, 1, one-cycle request to begin a frame.
- s_valid, in, 1, input pixel valid.
- s_data, in, DATA_WIDTH, input pixel.
- s_last, in, 1, marks the final pixel of the frame.
- s_ready, out, 1, writer accepts a pixel.
- ena, out, 1, image RAM port A enable.
- wea, out, 1, image RAM port A write enable.
- addra, out, ADDR_WIDTH, image RAM port A address.
- dina, out, DATA_WIDTH, image RAM port A write data.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle frame-complete pulse.
- err_len, out, 1, sticky frame-length error.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, PAD and DONE.
REQ-004 Transitions:
- IDLE->LOAD on start=1.
- LOAD->PAD on the accepted beat with index IMG_PIXELS-1, or on an accepted beat with s_last=1.
- PAD->DONE after the write to address 2^ADDR_WIDTH-1.
- DONE->IDLE unconditionally.
- When PAD_ZERO=0, LOAD->DONE directly.
REQ-005 s_ready SHALL be 1 only in LOAD; a beat is accepted when s_valid=1 and s_ready=1.
REQ-006 Each accepted beat SHALL produce ena=1, wea=1, addra=pixel index, dina=s_data, registered and visible the cycle after acceptance (latency 1).
REQ-007 The pixel index SHALL start at 0 on entry to LOAD and increment by 1 per accepted beat; stall cycles (s_valid=0) SHALL produce ena=0, wea=0.
REQ-008 PAD SHALL write dina=0 with ena=wea=1 on every cycle, from the address after the last pixel written through 2^ADDR_WIDTH-1 inclusive.
REQ-009 The PAD counter SHALL stop at 2^ADDR_WIDTH-1 and never wrap to 0.
REQ-010 err_len SHALL be set when either:
- s_last=1 is accepted at an index below IMG_PIXELS-1, or
- index IMG_PIXELS-1 is accepted with s_last=0.
err_len SHALL hold until the next accepted start, which clears it.
REQ-011 On an early s_last, PAD SHALL begin at the next address, so the frame is zero-filled from there.
REQ-012 busy SHALL be 1 in LOAD, PAD and DONE, and 0 in IDLE.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 done SHALL be 1 for exactly one cycle in DONE, the cycle after the last RAM write is presented.
REQ-015 start and done in the same cycle SHALL be legal: start is ignored, and a new start is accepted from the following IDLE cycle.
REQ-016 Nothing SHALL be written to the RAM outside LOAD and PAD; ena and wea SHALL be 0 in IDLE and DONE.

Reset
REQ-017 While rst_n=0 at a rising edge, the block SHALL:
- go to IDLE with the counter at 0;
- drive s_ready=0, ena=0, wea=0, addra=0, dina=0, busy=0, done=0, err_len=0.
REQ-018 Reset mid-frame SHALL abort with no further writes; RAM contents already written are left unchanged.

Structure
REQ-019 The FSM state encoding, IMG_PIXELS and the image dimension constants (28, 28) SHALL live in the shared lenet package used by the image RAM and the convolution blocks.
REQ-020 The block SHALL be one module with no sub-modules; the port A outputs SHALL connect directly to image_ram_wrapper port A.

Verification
REQ-021 The bench SHALL instantiate image_ram_writer driving image_ram_wrapper port A, with port B read-back at one-cycle read latency, on a 100 MHz clk.
REQ-022 Scenarios:
- Full frame: start, then 784 back-to-back beats with s_data=(i%28)+(i/28) and s_last at i=783 -> read-back matches for 0..783; 784..1023 read 0x00; done pulses once; err_len=0.
- Stalls: same frame with s_valid toggled at random -> identical RAM image; ena=0 on every stall cycle.
- Early last: s_last at i=99 -> err_len=1; addresses 100..1023 read 0x00; done pulses.
- Missing last: 784 beats with no s_last -> err_len=1; s_ready=0 after beat 783; no further writes from the stream.
- Reset mid-frame: rst_n=0 after beat 300, then a new full frame of 0xAA -> all 784 pixels read 0xAA; err_len=0.
- Ignored start: start pulsed during LOAD and in the DONE cycle -> no restart; the index continues; exactly one done per frame.
